imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader; holds the CPU in reset until a load completes.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the last word.
module imem_loader #(
  parameter int DEPTH = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [5:0]  word_count_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        im_we_o,
  output logic [31:0] im_addr_o,
  output logic [31:0] im_data_o,
  output logic        cpu_rst_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [5:0]  idx;
  logic [5:0]  cnt;
  logic [1:0]  bcnt;
  logic [31:0] word;
  logic        cpu_ok;
  logic        acc;
  logic        last;
  logic        pass;
  logic [5:0]  cnt_in;

  assign acc    = byte_valid_i && (state == S_RECV);
  assign last   = (idx == cnt - 6'd1);
  assign cnt_in = (word_count_i > 6'(DEPTH)) ? 6'(DEPTH)
                                             : word_count_i;

  assign im_addr_o = {24'd0, idx, 2'b00};
  assign im_data_o = word;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic       err_q;
  logic [7:0] xsum;
  assign pass  = !err_q;
  assign err_o = err_q;
`else
  assign pass  = 1'b1;
  assign err_o = 1'b0;
`endif

  always_comb begin
    nxt          = state;
    byte_ready_o = 1'b0;
    im_we_o      = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    cpu_rst_o    = cpu_ok;
    unique case (state)
      S_IDLE: begin
        if (start_i)
          nxt = (word_count_i == 6'd0) ? S_DONE : S_RECV;
      end
      S_RECV: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
        cpu_rst_o    = 1'b0;
        if (acc && bcnt == 2'd3)
          nxt = S_WRITE;
      end
      S_WRITE: begin
        im_we_o   = 1'b1;
        busy_o    = 1'b1;
        cpu_rst_o = 1'b0;
        if (!last)
          nxt = S_RECV;
`ifdef IMEM_LOADER_CHECKSUM_EN
        else
          nxt = S_CHECK;
`else
        else
          nxt = S_DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
        cpu_rst_o    = 1'b0;
        if (byte_valid_i)
          nxt = S_DONE;
      end
`endif
      S_DONE: begin
        done_o    = 1'b1;
        cpu_rst_o = pass;
        nxt       = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state  <= S_IDLE;
      idx    <= '0;
      cnt    <= '0;
      bcnt   <= '0;
      word   <= '0;
      cpu_ok <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      err_q  <= 1'b0;
      xsum   <= '0;
`endif
    end else begin
      state <= nxt;
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            idx    <= '0;
            bcnt   <= '0;
            cnt    <= cnt_in;
            cpu_ok <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            err_q  <= 1'b0;
            xsum   <= '0;
`endif
          end
        end
        S_RECV: begin
          if (acc) begin
            word <= {word[23:0], byte_i};
            bcnt <= bcnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xsum <= xsum ^ byte_i;
`endif
          end
        end
        S_WRITE: begin
          if (!last)
            idx <= idx + 6'd1;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (byte_valid_i && byte_i != xsum)
            err_q <= 1'b1;
        end
`endif
        S_DONE: begin
          if (pass)
            cpu_ok <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
